// File: rtl/trace_trigger_pkg.sv
// Shared types and helpers for the triggered trace capture buffer.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    localparam logic MODE_CHANGE = 1'b0;
    localparam logic MODE_EVERY  = 1'b1;

    // Readout words needed to carry one {timestamp, data} record.
    function automatic int rec_words(input int ts_w, input int data_w, input int out_w);
        return (ts_w + data_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/trace_trigger_if.sv
// Readout stream towards the debug pipe: valid/ready word transfer with a last marker.
interface trace_trigger_if #(
    parameter int OWIDTH = 32
) ();
    logic              ENA;
    logic [OWIDTH-1:0] v;
    logic              last;
    logic              RDY;

    modport master (output ENA, output v, output last, input RDY);
    modport slave  (input ENA, input v, input last, output RDY);
endinterface

// File: rtl/trace_trigger_bram.sv
// Simple dual-port record RAM: one write port, one registered read port.
module trace_bram #(
    parameter int DW    = 96,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; output holds when no read is issued.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule

// File: rtl/trace_trigger.sv
// Triggered trace capture: records timestamped samples into a circular RAM while armed,
// freezes after post_count records past the trigger, then drains the window oldest-first.
module trace_trigger
    import trace_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 1024,
    parameter int TS_WIDTH = 32,
    parameter int OWIDTH   = 32,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               enable,
    input  logic [WIDTH-1:0]   data,
    input  logic               mode,
    input  logic               trigger,
    input  logic [AW-1:0]      post_count,
    input  logic               arm,
    input  logic               rd_start,
    trace_trigger_if.master    out_enq,
    output logic [2:0]         state_o,
    output logic               wrapped,
    output logic [AW:0]        count
);
    localparam int RW = TS_WIDTH + WIDTH;
    localparam int R  = rec_words(TS_WIDTH, WIDTH, OWIDTH);
    localparam int PW = R * OWIDTH;
    localparam int WW = (R > 1) ? $clog2(R) : 1;

    localparam logic [AW:0]       CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [WW-1:0]     W_ZERO   = {WW{1'b0}};
    localparam logic [WW-1:0]     W_ONE    = WW'(1);
    localparam logic [WW-1:0]     W_LAST   = WW'(R - 1);
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]    prev_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, remain_q, remain_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d, rd_left_q, rd_left_d, rec_left_q, rec_left_d;
    logic                wrapped_q, wrapped_d, pf_valid_q, pf_valid_d, have_rec_q, have_rec_d;
    logic                cur_last_q, cur_last_d, ena_q, ena_d, last_q, last_d;
    logic [WW-1:0]       w_q, w_d, w_nxt_s;
    logic [RW-1:0]       rec_q, rec_d, dout_s;
    logic [OWIDTH-1:0]   v_q, v_d;
    logic [PW-1:0]       pad_rec_s, pad_dout_s;
    logic [OWIDTH-1:0]   rec_w_s [R];
    logic [OWIDTH-1:0]   dout_w_s [R];
    logic                rec_s, we_s, ren_s, clear_s;
    logic [AW-1:0]       raddr_s;

    trace_bram #(.DW(RW), .DEPTH(DEPTH)) u_bram (
        .clk_i   (CLK),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i ({ts_q, data}),
        .re_i    (ren_s),
        .raddr_i (raddr_s),
        .rdata_o (dout_s)
    );

    assign rec_s      = enable && ((mode == MODE_EVERY) || (data != prev_q));
    assign w_nxt_s    = w_q + W_ONE;
    assign pad_rec_s  = PW'(rec_q);
    assign pad_dout_s = PW'(dout_s);

    for (genvar g = 0; g < R; g++) begin : g_words
        assign rec_w_s[g]  = pad_rec_s[g*OWIDTH +: OWIDTH];
        assign dout_w_s[g] = pad_dout_s[g*OWIDTH +: OWIDTH];
    end

    // Capture/readout control: next state, buffer bookkeeping and output word selection.
    always_comb begin
        state_d    = state_q;    wr_ptr_d   = wr_ptr_q;   count_d    = count_q;
        wrapped_d  = wrapped_q;  remain_d   = remain_q;   rd_ptr_d   = rd_ptr_q;
        rd_left_d  = rd_left_q;  rec_left_d = rec_left_q; pf_valid_d = pf_valid_q;
        have_rec_d = have_rec_q; cur_last_d = cur_last_q; w_d        = w_q;
        rec_d      = rec_q;      ena_d      = ena_q;      v_d        = v_q;
        last_d     = last_q;
        we_s = 1'b0; ren_s = 1'b0; clear_s = 1'b0; raddr_s = rd_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (arm) begin
                    clear_s = 1'b1;
                end else if (trigger) begin
                    we_s     = 1'b1;
                    remain_d = post_count;
                    state_d  = (post_count == PTR_ZERO) ? ST_DONE : ST_POST;
                end else begin
                    we_s = rec_s;
                end
            end
            ST_POST: begin
                if (rec_s) begin
                    we_s     = 1'b1;
                    remain_d = remain_q - PTR_ONE;
                    state_d  = (remain_q == PTR_ONE) ? ST_DONE : ST_POST;
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                    clear_s = 1'b1;
                end else if (rd_start && (count_q != CNT_ZERO)) begin
                    // Oldest record is fetched now so the first word appears two cycles later.
                    state_d    = ST_READ;
                    ren_s      = 1'b1;
                    raddr_s    = wrapped_q ? wr_ptr_q : PTR_ZERO;
                    rd_ptr_d   = raddr_s + PTR_ONE;
                    rd_left_d  = count_q - CNT_ONE;
                    rec_left_d = count_q;
                    pf_valid_d = 1'b1;
                    have_rec_d = 1'b0;
                    ena_d      = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (ena_q && out_enq.RDY && last_q) begin
                    state_d = ST_IDLE;
                    ena_d   = 1'b0;
                    v_d     = {OWIDTH{1'b0}};
                    last_d  = 1'b0;
                end else if (!ena_q || out_enq.RDY) begin
                    if (have_rec_q && (w_q != W_LAST)) begin
                        w_d    = w_nxt_s;
                        v_d    = rec_w_s[w_nxt_s];
                        last_d = cur_last_q && (w_nxt_s == W_LAST);
                        ena_d  = 1'b1;
                    end else if (pf_valid_q && (rec_left_q != CNT_ZERO)) begin
                        // Take the prefetched record and immediately fetch the one after it.
                        rec_d      = dout_s;
                        w_d        = W_ZERO;
                        v_d        = dout_w_s[W_ZERO];
                        cur_last_d = (rec_left_q == CNT_ONE);
                        last_d     = (rec_left_q == CNT_ONE) && (W_LAST == W_ZERO);
                        have_rec_d = 1'b1;
                        ena_d      = 1'b1;
                        rec_left_d = rec_left_q - CNT_ONE;
                        if (rd_left_q != CNT_ZERO) begin
                            ren_s     = 1'b1;
                            rd_ptr_d  = rd_ptr_q + PTR_ONE;
                            rd_left_d = rd_left_q - CNT_ONE;
                        end else begin
                            pf_valid_d = 1'b0;
                        end
                    end else begin
                        ena_d = 1'b0;
                    end
                end else begin
                    ena_d = ena_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_s) begin
            wr_ptr_d  = PTR_ZERO;
            count_d   = CNT_ZERO;
            wrapped_d = 1'b0;
        end else if (we_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q == CNT_FULL) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Timestamp counter and previous-sample register run free from reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ts_q   <= {TS_WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            ts_q   <= ts_q + TS_ONE;
            prev_q <= data;
        end
    end

    // Control and output register bank.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;       wr_ptr_q   <= PTR_ZERO;  count_q    <= CNT_ZERO;
            wrapped_q  <= 1'b0;          remain_q   <= PTR_ZERO;  rd_ptr_q   <= PTR_ZERO;
            rd_left_q  <= CNT_ZERO;      rec_left_q <= CNT_ZERO;  pf_valid_q <= 1'b0;
            have_rec_q <= 1'b0;          cur_last_q <= 1'b0;      w_q        <= W_ZERO;
            rec_q      <= {RW{1'b0}};    ena_q      <= 1'b0;      v_q        <= {OWIDTH{1'b0}};
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;       wr_ptr_q   <= wr_ptr_d;  count_q    <= count_d;
            wrapped_q  <= wrapped_d;     remain_q   <= remain_d;  rd_ptr_q   <= rd_ptr_d;
            rd_left_q  <= rd_left_d;     rec_left_q <= rec_left_d; pf_valid_q <= pf_valid_d;
            have_rec_q <= have_rec_d;    cur_last_q <= cur_last_d; w_q       <= w_d;
            rec_q      <= rec_d;         ena_q      <= ena_d;     v_q        <= v_d;
            last_q     <= last_d;
        end
    end

    assign out_enq.ENA  = ena_q;
    assign out_enq.v    = v_q;
    assign out_enq.last = last_q;
    assign state_o      = state_q;
    assign wrapped      = wrapped_q;
    assign count        = count_q;
endmodule

// File: tb/tb_trace_trigger.sv
// Randomised scoreboard bench for trace_trigger: a queue-based window model predicts readout words.
module tb_trace_trigger;
    localparam int WIDTH = 64, DEPTH = 8, TS_WIDTH = 32, OWIDTH = 32, AW = 3;

    logic CLK = 1'b0;
    logic nRST = 1'b1;
    logic enable = 1'b0, mode = 1'b0, trigger = 1'b0, arm = 1'b0, rd_start = 1'b0;
    logic [WIDTH-1:0] data = 64'd0;
    logic [AW-1:0] post_count = 3'd0;
    logic [2:0] state_o;
    logic wrapped;
    logic [AW:0] count;

    trace_trigger_if #(.OWIDTH(OWIDTH)) out_enq ();

    trace_trigger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .OWIDTH(OWIDTH)) dut (
        .CLK(CLK), .nRST(nRST), .enable(enable), .data(data), .mode(mode), .trigger(trigger),
        .post_count(post_count), .arm(arm), .rd_start(rd_start), .out_enq(out_enq),
        .state_o(state_o), .wrapped(wrapped), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] v; logic last; } exp_t;
    exp_t sb[$];
    int n_checks = 0, n_pass = 0;

    // Reference model: the window is simply the newest DEPTH records in a queue.
    int          m_state = 0;
    int          m_remain = 0;
    logic [31:0] m_ts = 32'd0;
    logic [63:0] m_prev = 64'd0;
    logic [95:0] m_q[$];
    logic        m_wrapped = 1'b0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void m_add();
        if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_wrapped = 1'b1;
        end
        m_q.push_back({m_ts, data});
    endfunction

    function automatic void m_clear();
        m_q.delete();
        m_wrapped = 1'b0;
        m_state = 1;
    endfunction

    function automatic void m_expect_window();
        logic [95:0] r;
        for (int i = 0; i < m_q.size(); i++) begin
            for (int k = 0; k < 3; k++) begin
                r = m_q[i] >> (32 * k);
                sb.push_back('{r[31:0], (i == m_q.size() - 1) && (k == 2)});
            end
        end
    endfunction

    function automatic void m_edge();
        logic rec;
        rec = enable && (mode || (data != m_prev));
        case (m_state)
            0: if (arm) m_clear();
            1: begin
                if (arm) m_clear();
                else if (trigger) begin
                    m_add();
                    m_remain = int'(post_count);
                    m_state = (post_count == 3'd0) ? 3 : 2;
                end else if (rec) m_add();
            end
            2: if (rec) begin
                m_add();
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
            3: begin
                if (arm) m_clear();
                else if (rd_start && m_q.size() > 0) begin
                    m_expect_window();
                    m_state = 4;
                end
            end
            default: ;
        endcase
        m_prev = data;
        m_ts = m_ts + 32'd1;
    endfunction

    task automatic step();
        if (nRST) m_edge();
        @(posedge CLK);
        #1;
        if (nRST && m_state != 4) begin
            check("state", 128'(state_o), 128'(m_state));
            check("count", 128'(count), 128'(m_q.size()));
            check("wrapped", 128'(wrapped), 128'(m_wrapped));
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        check("rst_ena", 128'(out_enq.ENA), 128'd0);
        check("rst_v", 128'(out_enq.v), 128'd0);
        check("rst_last", 128'(out_enq.last), 128'd0);
        check("rst_state", 128'(state_o), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_wrapped", 128'(wrapped), 128'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        m_ts = 32'd0; m_prev = 64'd0; m_q.delete(); m_wrapped = 1'b0; m_state = 0;
        sb.delete();
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic start_drain();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        check("lat_not_yet", 128'(out_enq.ENA), 128'd0);
    endtask

    // rmode: 0 = ready always, 1 = ready toggling, 2 = random ready.
    task automatic finish_drain(input int rmode);
        int nwords, cyc;
        nwords = sb.size();
        out_enq.RDY = 1'b1;
        step();
        check("first_word_latency", 128'(out_enq.ENA), 128'd1);
        cyc = 0;
        while (sb.size() > 0 && cyc < 400) begin
            if (rmode == 1) out_enq.RDY = ~out_enq.RDY;
            else if (rmode == 2) out_enq.RDY = 1'($urandom_range(0, 1));
            else out_enq.RDY = 1'b1;
            step();
            cyc++;
        end
        check("drain_left", 128'(sb.size()), 128'd0);
        if (rmode == 0) check("no_bubbles", 128'(cyc), 128'(nwords));
        check("drain_state", 128'(state_o), 128'd0);
        check("drain_ena", 128'(out_enq.ENA), 128'd0);
        m_state = 0;
        out_enq.RDY = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic held, held_last;
        logic [31:0] held_v;
        exp_t e;
        held = 1'b0; held_last = 1'b0; held_v = 32'd0;
        forever begin
            @(negedge CLK);
            if (!nRST) held = 1'b0;
            else if (out_enq.ENA) begin
                if (held) begin
                    check("stall_v", 128'(out_enq.v), 128'(held_v));
                    check("stall_last", 128'(out_enq.last), 128'(held_last));
                end
                if (out_enq.RDY) begin
                    held = 1'b0;
                    if (sb.size() == 0) check("unexpected_word", 128'(out_enq.v), 128'hdead);
                    else begin
                        e = sb.pop_front();
                        check("word_v", 128'(out_enq.v), 128'(e.v));
                        check("word_last", 128'(out_enq.last), 128'(e.last));
                    end
                end else begin
                    held = 1'b1; held_v = out_enq.v; held_last = out_enq.last;
                end
            end else begin
                if (held) check("valid_dropped", 128'(out_enq.ENA), 128'd1);
                held = 1'b0;
            end
        end
    end

    initial begin
        out_enq.RDY = 1'b1;
        #1;
        do_reset();

        // Change-only capture: records at ts 10 (data change) and ts 12 (trigger).
        mode = 1'b0; enable = 1'b1; data = 64'd5;
        while (m_ts < 32'd2) step();
        pulse_arm();
        while (m_ts < 32'd10) step();
        data = 64'd7;
        while (m_ts < 32'd12) step();
        trigger = 1'b1; post_count = 3'd0; step(); trigger = 1'b0;
        check("t1_count", 128'(count), 128'd2);
        start_drain();
        finish_drain(0);

        // Word split of a known record, least-significant word first, zero padded.
        do_reset();
        mode = 1'b0; enable = 1'b1; data = 64'd0;
        pulse_arm();
        while (m_ts < 32'd5) step();
        data = 64'h1122334455667788; trigger = 1'b1; step(); trigger = 1'b0;
        start_drain();
        sb.delete();
        sb.push_back('{32'h55667788, 1'b0});
        sb.push_back('{32'h11223344, 1'b0});
        sb.push_back('{32'h00000005, 1'b1});
        finish_drain(0);

        // Every-cycle capture overflowing the buffer, drained with toggling ready.
        mode = 1'b1; enable = 1'b1;
        pulse_arm();
        repeat (20) begin data = {$urandom, $urandom}; step(); end
        trigger = 1'b1; post_count = 3'd3; step(); trigger = 1'b0;
        repeat (3) begin data = {$urandom, $urandom}; step(); end
        check("t2_wrapped", 128'(wrapped), 128'd1);
        check("t2_count", 128'(count), 128'd8);
        check("t2_state", 128'(state_o), 128'd3);
        start_drain();
        finish_drain(1);

        // arm beats trigger in the same cycle.
        pulse_arm();
        step();
        arm = 1'b1; trigger = 1'b1; step(); arm = 1'b0; trigger = 1'b0;
        check("armtrig_state", 128'(state_o), 128'd1);
        check("armtrig_count", 128'(count), 128'd0);

        // Reset in the middle of a drain, then rd_start must be ignored.
        mode = 1'b1;
        pulse_arm();
        repeat (5) begin data = {$urandom, $urandom}; step(); end
        trigger = 1'b1; post_count = 3'd0; step(); trigger = 1'b0;
        start_drain();
        repeat (4) step();
        do_reset();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        repeat (3) step();
        check("post_rst_ena", 128'(out_enq.ENA), 128'd0);
        check("post_rst_state", 128'(state_o), 128'd0);

        // Randomised sessions.
        for (int it = 0; it < 6; it++) begin
            int pre, budget;
            mode = 1'($urandom_range(0, 1));
            pulse_arm();
            pre = int'($urandom_range(3, 15));
            for (int c = 0; c < pre; c++) begin
                enable = 1'($urandom_range(0, 1)); data = 64'($urandom_range(0, 3)); step();
            end
            trigger = 1'b1; post_count = 3'($urandom_range(0, 7)); step(); trigger = 1'b0;
            budget = 0;
            while (m_state != 3 && budget < 300) begin
                enable = 1'($urandom_range(0, 1)); data = 64'($urandom_range(0, 3));
                trigger = 1'($urandom_range(0, 1));
                step();
                budget++;
            end
            trigger = 1'b0;
            check("rand_done", 128'(state_o), 128'd3);
            start_drain();
            finish_drain(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
